// File: rtl/fabric_frame_loader.sv
// Configuration front-end for the eFPGA: hunts for a sync word, decodes address+data packets,
// assembles a ROWS x 32-bit frame and pulses one FrameSelect bit. Define FRAME_LOADER_CHECKSUM_EN for the XOR checksum word.
module fabric_frame_loader #(
  parameter int          ROWS           = 3,
  parameter int          COLS           = 5,
  parameter int          FRAMES_PER_COL = 36,
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter int          DESYNC_BIT     = 20
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [31:0]                    in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [ROWS*32-1:0]             FrameRegister,
  output logic [COLS*FRAMES_PER_COL-1:0] FrameSelect,
  output logic                           synced,
  output logic [15:0]                    frames_written,
  output logic                           err
);

  localparam int SEL_W = COLS * FRAMES_PER_COL;
  localparam int K_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(ROWS - 1);

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    DATA,
`ifdef FRAME_LOADER_CHECKSUM_EN
    CHK,
`endif
    STROBE
  } state_t;

  state_t              state_q;
  logic [4:0]          col_q;
  logic [5:0]          frame_q;
  logic [K_W-1:0]      k_q;
  logic [ROWS*32-1:0]  frame_reg_q;
  logic [SEL_W-1:0]    sel_q;
  logic                synced_q;
  logic [15:0]         count_q;
  logic                err_q;
`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q;
`endif

  logic             accept;
  logic             addr_ok;
  logic             strobe_go;
  logic             strobe_good;
  logic [SEL_W-1:0] sel_d;
  int               sel_idx;

  // in_ready is forced low while reset is held so no word is lost to the reset edge
  assign in_ready = !RST && (state_q != STROBE);
  assign accept   = in_valid && in_ready;
  assign addr_ok  = (int'(col_q) < COLS) && (int'(frame_q) < FRAMES_PER_COL);

  always_comb begin
    sel_idx = int'(col_q) * FRAMES_PER_COL + int'(frame_q);
    sel_d   = '0;
    for (int i = 0; i < SEL_W; i++) sel_d[i] = (i == sel_idx);
`ifdef FRAME_LOADER_CHECKSUM_EN
    strobe_go   = accept && (state_q == CHK);
    strobe_good = addr_ok && (in_data == csum_q);
`else
    strobe_go   = accept && (state_q == DATA) && (k_q == K_LAST);
    strobe_good = addr_ok;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= HUNT;
      col_q       <= '0;
      frame_q     <= '0;
      k_q         <= '0;
      frame_reg_q <= '0;
      sel_q       <= '0;
      synced_q    <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      sel_q <= '0;
      case (state_q)
        HUNT: if (accept && in_data == SYNC_WORD) begin
          state_q  <= ADDR;
          synced_q <= 1'b1;
        end
        ADDR: if (accept) begin
          if (in_data[DESYNC_BIT]) begin
            state_q  <= HUNT;
            synced_q <= 1'b0;
          end else begin
            col_q   <= in_data[12:8];
            frame_q <= in_data[5:0];
            k_q     <= '0;
            state_q <= DATA;
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_q  <= in_data;
`endif
          end
        end
        DATA: if (accept) begin
          // First data word of a packet lands in the most significant slice
          frame_reg_q[32*(ROWS-1-int'(k_q)) +: 32] <= in_data;
          k_q <= k_q + 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ in_data;
          if (k_q == K_LAST) state_q <= CHK;
`else
          if (k_q == K_LAST) state_q <= STROBE;
`endif
        end
`ifdef FRAME_LOADER_CHECKSUM_EN
        CHK: if (accept) state_q <= STROBE;
`endif
        STROBE: state_q <= ADDR;
        default: state_q <= HUNT;
      endcase

      // Strobe is registered on the accepting edge so it is high for the STROBE cycle only
      if (strobe_go) begin
        if (strobe_good) begin
          sel_q <= sel_d;
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign FrameRegister  = frame_reg_q;
  assign FrameSelect    = sel_q;
  assign synced         = synced_q;
  assign frames_written = count_q;
  assign err            = err_q;

endmodule
